// File: rtl/logic_unit_pipe.sv
// WIDTH-bit 8-opcode bitwise unit with multi-beat frame fold; LOGIC_XCHECK_EN adds out_xz X/Z tracking.
// Latency 2 cycles accept-to-out_valid; 1 beat/cycle; whole pipe stalls while out_valid && !out_ready.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_abort
`ifdef LOGIC_XCHECK_EN
    ,
    output logic             out_xz
`endif
);

    function automatic logic [WIDTH-1:0] op_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // The frame's first opcode selects the reduction; NOT/PASS frames keep the newest beat.
    function automatic logic [WIDTH-1:0] fold_eval(input logic [2:0] fop,
                                                   input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] r);
        case (fop)
            3'd0, 3'd2: return acc & r;
            3'd1, 3'd3: return acc | r;
            3'd4, 3'd5: return acc ^ r;
            default:    return r;
        endcase
    endfunction

    logic             advance;
    logic             s1_vld, s1_acc, s1_last;
    logic [WIDTH-1:0] s1_r;
    logic [2:0]       s1_op;

    logic             frame_open, open_d;
    logic [WIDTH-1:0] acc_reg, acc_d, fold_val;
    logic [2:0]       fold_op, fop_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;

    logic             emit, emit_abort;
    logic [WIDTH-1:0] emit_val, emit_dat;
    logic [CNT_W-1:0] emit_cnt;

    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;
    assign fold_val = fold_eval(fold_op, acc_reg, s1_r);
    assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef LOGIC_XCHECK_EN
    logic [WIDTH-1:0] in_xm, s1_xm, acc_xm, xm_d, emit_xm, fold_xm;
    logic             acc_xz, xz_d, emit_xz, fold_xz;

    // Per-bit unknown mask: b only feeds the two-operand opcodes.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            in_xm[i] = (in_a[i] === 1'bx) || (in_a[i] === 1'bz) ||
                       ((in_op < 3'd6) && ((in_b[i] === 1'bx) || (in_b[i] === 1'bz)));
        end
    end

    assign fold_xm  = (fold_op >= 3'd6) ? s1_xm : (acc_xm | s1_xm);
    assign fold_xz  = acc_xz | (|s1_xm);
    assign emit_dat = emit_val & ~emit_xm;
`else
    assign emit_dat = emit_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_r    <= '0;
            s1_op   <= '0;
            s1_acc  <= 1'b0;
            s1_last <= 1'b0;
`ifdef LOGIC_XCHECK_EN
            s1_xm   <= '0;
`endif
        end else if (advance) begin
            s1_vld  <= in_valid;
            s1_r    <= op_eval(in_op, in_a, in_b);
            s1_op   <= in_op;
            s1_acc  <= in_acc;
            s1_last <= in_last;
`ifdef LOGIC_XCHECK_EN
            s1_xm   <= in_xm;
`endif
        end
    end

    always_comb begin
        emit       = 1'b0;
        emit_val   = s1_r;
        emit_cnt   = CNT_W'(1);
        emit_abort = 1'b0;
        open_d     = frame_open;
        acc_d      = acc_reg;
        fop_d      = fold_op;
        cnt_d      = cnt;
`ifdef LOGIC_XCHECK_EN
        emit_xm    = s1_xm;
        emit_xz    = |s1_xm;
        xm_d       = acc_xm;
        xz_d       = acc_xz;
`endif
        if (s1_vld) begin
            if (!s1_acc) begin
                // A plain beat arriving inside a frame discards that frame.
                emit       = 1'b1;
                emit_abort = frame_open;
                open_d     = 1'b0;
            end else if (!frame_open) begin
                if (s1_last) begin
                    emit = 1'b1;
                end else begin
                    open_d = 1'b1;
                    acc_d  = s1_r;
                    fop_d  = s1_op;
                    cnt_d  = CNT_W'(1);
`ifdef LOGIC_XCHECK_EN
                    xm_d   = s1_xm;
                    xz_d   = |s1_xm;
`endif
                end
            end else if (s1_last) begin
                emit     = 1'b1;
                emit_val = fold_val;
                emit_cnt = cnt_inc;
                open_d   = 1'b0;
`ifdef LOGIC_XCHECK_EN
                emit_xm  = fold_xm;
                emit_xz  = fold_xz;
`endif
            end else begin
                acc_d = fold_val;
                cnt_d = cnt_inc;
`ifdef LOGIC_XCHECK_EN
                xm_d  = fold_xm;
                xz_d  = fold_xz;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_open <= 1'b0;
            acc_reg    <= '0;
            fold_op    <= '0;
            cnt        <= '0;
`ifdef LOGIC_XCHECK_EN
            acc_xm     <= '0;
            acc_xz     <= 1'b0;
`endif
        end else if (advance) begin
            frame_open <= open_d;
            acc_reg    <= acc_d;
            fold_op    <= fop_d;
            cnt        <= cnt_d;
`ifdef LOGIC_XCHECK_EN
            acc_xm     <= xm_d;
            acc_xz     <= xz_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_abort <= 1'b0;
`ifdef LOGIC_XCHECK_EN
            out_xz    <= 1'b0;
`endif
        end else if (advance) begin
            out_valid <= emit;
            if (emit) begin
                out_data  <= emit_dat;
                out_beats <= emit_cnt;
                out_abort <= emit_abort;
`ifdef LOGIC_XCHECK_EN
                out_xz    <= emit_xz;
`endif
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: opcode table, frame/backpressure/abort/reset sequences, randomized run vs stream model.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_ready2;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;
    logic       in_acc, in_last;
    logic       out_valid, out_valid2, out_ready;
    logic [7:0] out_data, out_data2;
    logic [3:0] out_beats;
    logic [1:0] out_beats2;
    logic       out_abort, out_abort2;
`ifdef LOGIC_XCHECK_EN
    logic       out_xz, out_xz2;
`endif

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_beats(out_beats), .out_abort(out_abort)
`ifdef LOGIC_XCHECK_EN
        , .out_xz(out_xz)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_beats(out_beats2), .out_abort(out_abort2)
`ifdef LOGIC_XCHECK_EN
        , .out_xz(out_xz2)
`endif
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        int         n;
        logic       ab;
    } exp_t;

    int         checks = 0;
    int         failures = 0;
    int         n_out = 0;
    exp_t       exp_q[$];
    logic       m_open = 1'b0;
    logic [7:0] m_acc;
    logic [2:0] m_fop;
    int         m_n;
    logic [7:0] cap_d;
    logic [3:0] cap_b;
    logic [1:0] cap_b2;
    logic       cap_ab;
    logic       cap_xz;
    bit         rnd_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Stream-level reference: consumes accepted beats, queues the results the sink should see.
    task automatic model_beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic acc, input logic last);
        logic [7:0] r;
        exp_t       e;
        r = ref_op(op, a, b);
`ifdef LOGIC_XCHECK_EN
        for (int i = 0; i < 8; i++)
            if ((a[i] !== 1'b0 && a[i] !== 1'b1) || (op < 3'd6 && b[i] !== 1'b0 && b[i] !== 1'b1))
                r[i] = 1'b0;
`endif
        if (!acc) begin
            e.d = r; e.n = 1; e.ab = m_open;
            exp_q.push_back(e);
            m_open = 1'b0;
        end else begin
            if (!m_open) begin
                m_acc = r; m_fop = op; m_n = 1; m_open = 1'b1;
            end else begin
                m_n++;
                case (m_fop)
                    3'd0, 3'd2: m_acc = m_acc & r;
                    3'd1, 3'd3: m_acc = m_acc | r;
                    3'd4, 3'd5: m_acc = m_acc ^ r;
                    default:    m_acc = r;
                endcase
            end
            if (last) begin
                e.d = m_acc; e.n = m_n; e.ab = 1'b0;
                exp_q.push_back(e);
                m_open = 1'b0;
            end
        end
    endtask

    task automatic monitor_step();
        exp_t       e;
        logic [3:0] eb4;
        logic [1:0] eb2;
        if (!rst_n) begin
            m_open = 1'b0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_stream unexpected output data=%h, none required", out_data);
                end else begin
                    e   = exp_q.pop_front();
                    eb4 = (e.n > 15) ? 4'd15 : 4'(e.n);
                    eb2 = (e.n > 3) ? 2'd3 : 2'(e.n);
                    if (out_data !== e.d || out_beats !== eb4 || out_abort !== e.ab ||
                        out_valid2 !== 1'b1 || in_ready2 !== in_ready || out_data2 !== e.d ||
                        out_beats2 !== eb2 || out_abort2 !== e.ab) begin
                        failures++;
                        $display("FAIL out_stream actual data=%h beats=%0d/%0d abort=%b required data=%h beats=%0d/%0d abort=%b",
                                 out_data, out_beats, out_beats2, out_abort, e.d, eb4, eb2, e.ab);
                    end
                end
            end
            if (in_valid && in_ready) model_beat(in_op, in_a, in_b, in_acc, in_last);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic acc, input logic last);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; in_last = last;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic last);
        bit ok;
        ok = 0;
        drive(op, a, b, acc, last);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=0 required 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_timeout out_valid=0 required 1", name);
        end
        cap_d = out_data; cap_b = out_beats; cap_b2 = out_beats2; cap_ab = out_abort;
`ifdef LOGIC_XCHECK_EN
        cap_xz = out_xz;
`else
        cap_xz = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   n_base;
        tbl[0] = '{3'd0, 8'hA5, 8'h3C, 8'h24};
        tbl[1] = '{3'd1, 8'hA5, 8'h3C, 8'hBD};
        tbl[2] = '{3'd2, 8'hA5, 8'h3C, 8'hDB};
        tbl[3] = '{3'd3, 8'hA5, 8'h3C, 8'h42};
        tbl[4] = '{3'd4, 8'hA5, 8'h3C, 8'h99};
        tbl[5] = '{3'd5, 8'hA5, 8'h3C, 8'h66};
        tbl[6] = '{3'd6, 8'hA5, 8'h3C, 8'h5A};
        tbl[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        fork
            forever begin @(negedge clk); monitor_step(); end
        join_none

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_beats", out_beats, 0);
        chk("rst_out_abort", out_abort, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beats: output must appear exactly on the second edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("op%0d_early", i), out_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("op%0d_valid", i), out_valid, 1);
            chk($sformatf("op%0d_data", i), out_data, tbl[i].exp);
            chk($sformatf("op%0d_beats", i), out_beats, 1);
        end
        @(posedge clk); #1;

        // XOR frame: no output until the last beat has been folded.
        drive(3'd4, 8'h01, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1; chk("xorf_mid0", out_valid, 0);
        drive(3'd4, 8'h02, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1; chk("xorf_mid1", out_valid, 0);
        drive(3'd4, 8'h04, 8'h00, 1'b1, 1'b1);
        @(posedge clk); #1; chk("xorf_mid2", out_valid, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("xorf_valid", out_valid, 1);
        chk("xorf_data", out_data, 8'h07);
        chk("xorf_beats", out_beats, 3);
        @(posedge clk); #1;

        // Backpressure: sink stalls for 5 cycles while 3 singles are offered.
        n_base = n_out;
        out_ready = 1'b0;
        fork
            begin
                send(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0);
                send(3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
                send(3'd4, 8'hFF, 8'h0F, 1'b0, 1'b0);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) begin seen = 1; break; end
                end
                chk("bp_first_valid", seen, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold_data", out_data, 8'h30);
                end
                @(posedge clk); #2 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1 chk("bp_delivered", n_out - n_base, 3);

        // CNT_W=2 instance saturates at 3; the 4-bit one counts all 5 beats.
        for (int i = 0; i < 5; i++) send(3'd0, 8'hFF, 8'hF0, 1'b1, i == 4);
        wait_out("sat");
        chk("sat_data", cap_d, 8'hF0);
        chk("sat_beats_w2", cap_b2, 3);
        chk("sat_beats_w4", cap_b, 5);

        // Open OR frame interrupted by a plain AND beat.
        send(3'd1, 8'h01, 8'h02, 1'b1, 1'b0);
        send(3'd1, 8'h04, 8'h00, 1'b1, 1'b0);
        send(3'd0, 8'h0F, 8'hFF, 1'b0, 1'b0);
        wait_out("abort");
        chk("abort_data", cap_d, 8'h0F);
        chk("abort_flag", cap_ab, 1);
        chk("abort_beats", cap_b, 1);
        send(3'd4, 8'h03, 8'h00, 1'b1, 1'b0);
        send(3'd4, 8'h05, 8'h00, 1'b1, 1'b1);
        wait_out("clean");
        chk("clean_data", cap_d, 8'h06);
        chk("clean_abort", cap_ab, 0);
        chk("clean_beats", cap_b, 2);

        // Asynchronous reset mid-cycle with a held output and a frame beat in flight.
        out_ready = 1'b0;
        send(3'd0, 8'h33, 8'h0F, 1'b0, 1'b0);
        send(3'd1, 8'h11, 8'h22, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_beats", out_beats, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_base = n_out;
        send(3'd6, 8'h00, 8'h5A, 1'b0, 1'b0);
        wait_out("post_rst");
        chk("post_rst_data", cap_d, 8'hFF);
        chk("post_rst_abort", cap_ab, 0);
        chk("post_rst_count", n_out - n_base, 1);

`ifdef LOGIC_XCHECK_EN
        send(3'd0, 8'b0000_xxxx, 8'hFF, 1'b0, 1'b0);
        wait_out("xz");
        chk("xz_flag", cap_xz, 1);
        chk("xz_data", cap_d, 8'h00);
        send(3'd0, 8'h0F, 8'hFF, 1'b0, 1'b0);
        wait_out("xz_clean");
        chk("xz_clean_flag", cap_xz, 0);
`endif

        // Randomized traffic with a randomly stalling sink.
        n_base = n_out;
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 400; k++)
                    send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                         1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        send(3'd7, 8'h5C, 8'h00, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_outputs_seen", (n_out - n_base) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-bit combinational gate block.
- WIDTH-bit bitwise logic unit with 8 opcodes and valid/ready handshakes on input and output.
- Multi-beat frame reduction: per-beat results fold into an accumulator; one result is emitted per frame.
- Sits between a stream source and sink. Used for mask/parity/flag reduction in datapath blocks.

Parameters:
- WIDTH, 8, data width of a, b and result.
- CNT_W, 4, width of beat counter out_beats; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b (ignored by opcodes 6, 7)
- in_op  in  3  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a
- in_acc  in  1  beat belongs to a reduction frame
- in_last  in  1  final beat of a frame (meaningful only with in_acc=1)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_data  out  WIDTH  result
- out_beats  out  CNT_W  number of beats folded into out_data (1 for single beats)
- out_abort  out  1  this output follows a discarded, unterminated frame

Behaviour:
- Reset (rst_n=0, asynchronous): clears all registers. Outputs go to out_valid=0, out_data=0, out_beats=0, out_abort=0, and the frame state is idle.
- in_ready = !out_valid || out_ready (combinational). Define advance = in_ready. When advance=0 the whole pipe holds.
- Stage 1 (on advance): registers r = op(in_a, in_b), together with op, acc, last and valid = in_valid. If in_valid=0 it loads a bubble.
- Stage 2 (on advance with s1 valid):
  - acc=0: emit out_data=r, out_beats=1, out_valid=1. If a frame was open, set out_abort=1, else 0. Frame becomes idle.
  - acc=1 and frame idle: acc_reg=r, fold_op latched from op, cnt=1, frame opens.
  - acc=1 and frame open: acc_reg = fold(acc_reg, r), cnt = saturating cnt+1.
  - acc=1 and last=1: emit the folded value and cnt. out_abort=1 only if the frame had been aborted (never for a clean frame). Frame becomes idle.
  - acc=1 and last=0: out_valid=0 on the next cycle.
- Stage 2 on advance with s1 empty: out_valid=0.
- A first beat with acc=1, last=1 is a 1-beat frame: out_data=r, out_beats=1.
- Fold table, keyed on fold_op from the frame's first beat:
  - ops 0, 2: AND.
  - ops 1, 3: OR.
  - ops 4, 5: XOR.
  - ops 6, 7: replace (last beat wins).
  - Later beats use their own op for r, but fold_op does not change.
- Latency: a single beat accepted at cycle N appears as out_valid at N+2 when there is no backpressure. Throughput is 1 beat/cycle.
- Backpressure: out_data, out_beats and out_abort stay stable while out_valid && !out_ready. Nothing is lost or duplicated.
- Counter: cnt saturates at 2^CNT_W-1. The fold itself continues past saturation.
- Reset mid-frame: the accumulator and frame are discarded. No output and no abort flag are produced after reset.

Optional Feature:
- Macro: LOGIC_XCHECK_EN.
- Defined:
  - Adds output port out_xz (1 bit, reset 0).
  - out_xz is set if any bit of in_a, or of in_b for ops 0-5, was X or Z on any beat folded into the emitted result.
  - out_data bits derived from X/Z inputs are forced to 0.
  - The flag is sticky within a frame.
  - Simulation-oriented; uses case-equality detection.
- Undefined: out_xz port is absent and X/Z propagates through the logic unchanged.

Test Plan:
- Each op 0..7, a=8'hA5, b=8'h3C, acc=0 → out_data 24, BD, DB, 42, 99, 66, 5A, A5; out_beats=1; each result 2 cycles after accept.
- XOR frame: beats (a,b) = (01,00), (02,00), (04,00, last) → single output 8'h07, out_beats=3; no out_valid on intermediate beats.
- out_ready=0 for 5 cycles with 3 single beats offered → in_ready=0 while the output is held; out_data stable; all 3 results delivered in order once out_ready=1.
- CNT_W=2, AND frame of 5 beats a=FF, b=F0 → out_data=F0, out_beats=3 (saturated).
- Open OR frame (2 beats), then a single beat AND a=0F, b=FF → out_data=0F, out_abort=1; the next clean frame gives out_abort=0.
- rst_n low mid-frame for 1 cycle, asynchronously mid-cycle → out_valid=0 immediately. A following single NOT a=00 → FF, out_abort=0. With LOGIC_XCHECK_EN, a=8'h0x, op AND → out_xz=1.
